// File: rtl/frame_capture_ctrl.sv
// Camera frame capture controller: crops a FRAME_WIDTH x FRAME_HEIGHT
// window out of a pixel stream and writes it into a frame buffer BRAM.
//
// Ports:
//   clk_in          - single clock, rising edge
//   rst_n_in        - synchronous active-low reset
//   capture_req_in  - start request pulse (accepted in IDLE only)
//   continuous_in   - re-arm automatically after each completed frame
//   abort_in        - cancel capture, return to IDLE next cycle
//   crop_x_in/y_in  - window top-left corner, latched on arm
//   pixel_*_in      - pixel strobe, column, row and RGB565 data
//   bram_*_out      - frame buffer write port (we/addr/data)
//   busy_out        - high in ARM and CAPTURE
//   frame_done_out  - pulse with the final write of a frame
//   short_frame_out - pulse when a new frame starts before completion
//   frame_count_out - completed frame counter, wraps at 2^16
module frame_capture_ctrl #(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 180,
  localparam int ADDR_WIDTH  = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    capture_req_in,
  input  logic                    continuous_in,
  input  logic                    abort_in,
  input  logic [HCOUNT_WIDTH-1:0] crop_x_in,
  input  logic [VCOUNT_WIDTH-1:0] crop_y_in,
  input  logic                    pixel_valid_in,
  input  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in,
  input  logic [15:0]             pixel_data_in,
  output logic                    bram_we_out,
  output logic [ADDR_WIDTH-1:0]   bram_addr_out,
  output logic [15:0]             bram_data_out,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic                    short_frame_out,
  output logic [15:0]             frame_count_out
);

  localparam int HW1 = HCOUNT_WIDTH + 1;
  localparam int VW1 = VCOUNT_WIDTH + 1;

  localparam logic [HCOUNT_WIDTH:0] FW_X =
    HW1'(FRAME_WIDTH);
  localparam logic [VCOUNT_WIDTH:0] FH_X =
    VW1'(FRAME_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE =
    ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                  state;
  logic [HCOUNT_WIDTH-1:0] crop_x_q;
  logic [VCOUNT_WIDTH-1:0] crop_y_q;
  logic [ADDR_WIDTH-1:0]   wr_count;

  logic                    frame_start;
  logic [HCOUNT_WIDTH:0]   h_ext;
  logic [HCOUNT_WIDTH:0]   x_lo;
  logic [HCOUNT_WIDTH:0]   x_hi;
  logic [VCOUNT_WIDTH:0]   v_ext;
  logic [VCOUNT_WIDTH:0]   y_lo;
  logic [VCOUNT_WIDTH:0]   y_hi;
  logic                    in_win;
  logic                    active;
  logic [ADDR_WIDTH-1:0]   eff_count;
  logic                    accept;
  logic                    is_last;

  assign frame_start = pixel_valid_in
                     && (pixel_hcount_in == '0)
                     && (pixel_vcount_in == '0);

  // One extra bit keeps crop+size from wrapping past counter range.
  assign h_ext = {1'b0, pixel_hcount_in};
  assign x_lo  = {1'b0, crop_x_q};
  assign x_hi  = x_lo + FW_X;
  assign v_ext = {1'b0, pixel_vcount_in};
  assign y_lo  = {1'b0, crop_y_q};
  assign y_hi  = y_lo + FH_X;

  assign in_win = (h_ext >= x_lo) && (h_ext < x_hi)
               && (v_ext >= y_lo) && (v_ext < y_hi);

  // The frame-start pixel seen in ARM is already a capture pixel.
  assign active = (state == CAPTURE)
               || ((state == ARM) && frame_start);

  // Any frame start restarts addressing at zero.
  assign eff_count = frame_start ? '0 : wr_count;

  assign accept  = active && pixel_valid_in && in_win;
  assign is_last = accept && (eff_count == LAST_ADDR);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      crop_x_q        <= '0;
      crop_y_q        <= '0;
      wr_count        <= '0;
      bram_we_out     <= 1'b0;
      bram_addr_out   <= '0;
      bram_data_out   <= '0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      short_frame_out <= 1'b0;
      frame_count_out <= '0;
    end else begin
      bram_we_out     <= 1'b0;
      frame_done_out  <= 1'b0;
      short_frame_out <= 1'b0;
      if (abort_in) begin
        state    <= IDLE;
        wr_count <= '0;
        busy_out <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (capture_req_in) begin
              crop_x_q <= crop_x_in;
              crop_y_q <= crop_y_in;
              state    <= ARM;
              busy_out <= 1'b1;
            end
          end
          ARM, CAPTURE: begin
            if (active) begin
              state    <= CAPTURE;
              busy_out <= 1'b1;
              wr_count <= eff_count;
              if ((state == CAPTURE) && frame_start) begin
                short_frame_out <= 1'b1;
              end
              if (accept) begin
                bram_we_out   <= 1'b1;
                bram_addr_out <= eff_count;
                bram_data_out <= pixel_data_in;
                wr_count      <= eff_count + ADDR_ONE;
              end
              if (is_last) begin
                frame_done_out  <= 1'b1;
                frame_count_out <= frame_count_out + 16'd1;
                wr_count        <= '0;
                if (continuous_in) begin
                  state    <= ARM;
                  crop_x_q <= crop_x_in;
                  crop_y_q <= crop_y_in;
                end else begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
                end
              end
            end
          end
          default: begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl with a 4x2 window
// cropped out of an 8x4 pixel stream.
module tb_frame_capture_ctrl;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int SW = 8;
  localparam int SH = 4;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        cont;
  logic        abort;
  logic [10:0] crop_x;
  logic [9:0]  crop_y;
  logic        pv;
  logic [10:0] ph;
  logic [9:0]  pvc;
  logic [15:0] pd;
  logic        we;
  logic [2:0]  addr;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic        shrt;
  logic [15:0] fcnt;

  frame_capture_ctrl #(
    .HCOUNT_WIDTH (11),
    .VCOUNT_WIDTH (10),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .capture_req_in  (req),
    .continuous_in   (cont),
    .abort_in        (abort),
    .crop_x_in       (crop_x),
    .crop_y_in       (crop_y),
    .pixel_valid_in  (pv),
    .pixel_hcount_in (ph),
    .pixel_vcount_in (pvc),
    .pixel_data_in   (pd),
    .bram_we_out     (we),
    .bram_addr_out   (addr),
    .bram_data_out   (data),
    .busy_out        (busy),
    .frame_done_out  (done),
    .short_frame_out (shrt),
    .frame_count_out (fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: capture progress expressed as window geometry.
  bit          m_busy = 0;
  bit          m_act  = 0;
  int          m_cx   = 0;
  int          m_cy   = 0;
  logic [15:0] m_count = 0;
  logic        e_we, e_done, e_short;
  logic [2:0]  e_addr = 0;
  logic [15:0] e_data = 0;
  int          n_short = 0;
  int          n_done  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic v_in, input int h,
                      input int v, input logic [15:0] d);
    bit fs;
    bit inw;
    int a;
    pv  = v_in;
    ph  = h[10:0];
    pvc = v[9:0];
    pd  = d;
    e_we = 0;
    e_done = 0;
    e_short = 0;
    if (!rst_n) begin
      m_busy = 0;
      m_act = 0;
      m_count = 0;
      e_addr = 0;
      e_data = 0;
    end else if (abort) begin
      m_busy = 0;
      m_act = 0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy = 1;
        m_cx = int'(crop_x);
        m_cy = int'(crop_y);
      end
    end else begin
      fs = v_in && h == 0 && v == 0;
      if (fs && m_act) e_short = 1;
      if (fs) m_act = 1;
      if (m_act) begin
        inw = v_in && h >= m_cx && h < m_cx + FW
                   && v >= m_cy && v < m_cy + FH;
        if (inw) begin
          a = (v - m_cy) * FW + (h - m_cx);
          e_we = 1;
          e_addr = a[2:0];
          e_data = d;
          if (a == FW * FH - 1) begin
            e_done = 1;
            m_count++;
            m_act = 0;
            if (cont) begin
              m_cx = int'(crop_x);
              m_cy = int'(crop_y);
            end else begin
              m_busy = 0;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    req = 0;
    abort = 0;
    if (shrt) n_short++;
    if (done) n_done++;
    chk("we", 32'(we), 32'(e_we));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("data", 32'(data), 32'(e_data));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("short", 32'(shrt), 32'(e_short));
    chk("fcnt", 32'(fcnt), 32'(m_count));
  endtask

  task automatic idle_step();
    step(1'b0, $urandom_range(7), $urandom_range(3),
         16'($urandom));
  endtask

  // Stream raster pixels [first,last) of an 8x4 frame with
  // optional random invalid gaps between them.
  task automatic stream(input int first, input int last,
                        input bit gaps);
    for (int i = first; i < last; i++) begin
      if (gaps && $urandom_range(3) == 0) idle_step();
      step(1'b1, i % SW, i / SW, 16'($urandom));
    end
  endtask

  task automatic arm(input int cx, input int cy);
    crop_x = cx[10:0];
    crop_y = cy[9:0];
    req = 1;
    idle_step();
  endtask

  initial begin
    rst_n = 0;
    req = 0;
    cont = 0;
    abort = 0;
    crop_x = 0;
    crop_y = 0;
    pv = 0;
    ph = 0;
    pvc = 0;
    pd = 0;

    // Reset state
    idle_step();
    idle_step();
    rst_n = 1;
    idle_step();

    // Single shot, crop (0,0)
    arm(0, 0);
    stream(0, SW * SH, 0);
    idle_step();

    // Crop (2,1)
    arm(2, 1);
    stream(0, SW * SH, 1);
    idle_step();

    // Random crops with random gaps
    for (int k = 0; k < 4; k++) begin
      arm($urandom_range(SW - FW), $urandom_range(SH - FH));
      stream(0, SW * SH, 1);
    end

    // Continuous mode, three frames, busy must stay high
    cont = 1;
    arm(1, 1);
    for (int k = 0; k < 3; k++) begin
      crop_x = 11'($urandom_range(SW - FW));
      crop_y = 10'($urandom_range(SH - FH));
      stream(0, SW * SH, 1);
    end
    chk("cont_frames", 32'(fcnt), 32'(m_count));
    abort = 1;
    idle_step();
    cont = 0;

    // Short frame after 5 writes, then normal completion
    n_short = 0;
    arm(0, 0);
    stream(0, 9, 0);
    stream(0, SW * SH, 1);
    chk("short_seen", 32'(n_short), 32'd1);

    // Abort after address 3 with an in-window pixel pending
    n_done = 0;
    arm(0, 0);
    stream(0, 4, 0);
    abort = 1;
    step(1'b1, 0, 1, 16'($urandom));
    stream(9, SW * SH, 0);
    chk("abort_nodone", 32'(n_done), 32'd0);

    // Request during capture with new crop must be ignored
    arm(1, 0);
    stream(0, 6, 0);
    crop_x = 3;
    crop_y = 2;
    req = 1;
    stream(6, SW * SH, 0);

    // Request together with abort in IDLE: stays idle
    crop_x = 0;
    crop_y = 0;
    req = 1;
    abort = 1;
    idle_step();
    stream(0, SW * SH, 0);

    // Reset in the middle of a capture
    arm(0, 0);
    stream(0, 6, 0);
    rst_n = 0;
    step(1'b1, 6, 0, 16'($urandom));
    rst_n = 1;
    stream(7, SW * SH, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
